// File: rtl/asymdata_pkg.sv
// asymdata_pkg: shared ratio/width helpers and mode constants for the asymmetric FIFO buffers
package asymdata_pkg;
  localparam int ASYM_ERR_STICKY  = 0;
  localparam int ASYM_ERR_DYNAMIC = 1;
  localparam int ASYM_MSB_FIRST   = 0;
  localparam int ASYM_LSB_FIRST   = 1;
  function automatic int asym_ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction
  function automatic int asym_cnt_w(input int k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction
endpackage

// File: rtl/asymdata_subword_sel.sv
// asymdata_subword_sel: picks sub-word cnt (or K-1-cnt for MSB-first) out of a wide word
module asymdata_subword_sel
  import asymdata_pkg::*;
#(
  parameter int in_width   = 16,
  parameter int out_width  = 8,
  parameter int byte_order = ASYM_MSB_FIRST
) (
  input  logic [in_width-1:0]                                      i_word,
  input  logic [asym_cnt_w(asym_ratio(in_width, out_width))-1:0]   i_cnt,
  output logic [out_width-1:0]                                     o_sub
);
  localparam int K  = asym_ratio(in_width, out_width);
  localparam int CW = asym_cnt_w(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);
  logic [CW-1:0] w_idx;
  assign w_idx = (byte_order == ASYM_LSB_FIRST) ? i_cnt : LAST - i_cnt;
  assign o_sub = i_word[w_idx*out_width +: out_width];
endmodule

// File: rtl/asymdata_outbuf.sv
// asymdata_outbuf: pop-side wide-to-narrow buffer; hands out K sub-words per FIFO word
// and pops the FIFO combinationally as the last sub-word is taken.
module asymdata_outbuf
  import asymdata_pkg::*;
#(
  parameter int in_width   = 16,
  parameter int out_width  = 8,
  parameter int err_mode   = ASYM_ERR_STICKY,
  parameter int byte_order = ASYM_MSB_FIRST
) (
  input  logic                 clk_pop,
  input  logic                 rst_pop_n,
  input  logic                 init_pop_n,
  input  logic                 pop_req_n,
  input  logic [in_width-1:0]  data_in,
  input  logic                 fifo_empty,
  output logic                 pop_wd_n,
  output logic [out_width-1:0] data_out,
  output logic                 part_wd,
  output logic                 pop_error
);
  localparam int K  = asym_ratio(in_width, out_width);
  localparam int CW = asym_cnt_w(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);
  if (in_width % out_width != 0 || K < 2) begin : g_bad_ratio
    $error("asymdata_outbuf: in_width must be a multiple K>=2 of out_width");
  end
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_pop, w_uf, w_last;
  assign w_pop  = ~pop_req_n & ~fifo_empty;
  assign w_uf   = ~pop_req_n & fifo_empty;
  assign w_last = (r_cnt == LAST);
  always_ff @(posedge clk_pop or negedge rst_pop_n) begin
    if (!rst_pop_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (!init_pop_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_pop) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      r_err <= (err_mode == ASYM_ERR_DYNAMIC) ? w_uf : (r_err | w_uf);
    end
  end
  // init does not gate the word pop: the consumer still took the last sub-word
  assign pop_wd_n  = ~(w_pop & w_last);
  assign part_wd   = (r_cnt != '0);
  assign pop_error = r_err;
  asymdata_subword_sel #(
    .in_width  (in_width),
    .out_width (out_width),
    .byte_order(byte_order)
  ) u_sel (
    .i_word(data_in),
    .i_cnt (r_cnt),
    .o_sub (data_out)
  );
endmodule

// File: tb/tb_asymdata_outbuf.sv
// tb_asymdata_outbuf: directed checks of three buffer configurations sharing control inputs
module tb_asymdata_outbuf;
  logic clk = 1'b0, rst_n = 1'b0, init_n = 1'b1, req_n = 1'b1, empty = 1'b0;
  logic [15:0] d16 = 16'hA55A;
  logic [31:0] d32 = 32'h01020304;
  logic        wd0, wd1, wd2, pw0, pw1, pw2, pe0, pe1, pe2;
  logic [7:0]  q0, q1, q2;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  asymdata_outbuf #(.in_width(16), .out_width(8), .err_mode(0), .byte_order(0)) u0 (
    .clk_pop(clk), .rst_pop_n(rst_n), .init_pop_n(init_n), .pop_req_n(req_n), .data_in(d16),
    .fifo_empty(empty), .pop_wd_n(wd0), .data_out(q0), .part_wd(pw0), .pop_error(pe0));
  asymdata_outbuf #(.in_width(16), .out_width(8), .err_mode(1), .byte_order(1)) u1 (
    .clk_pop(clk), .rst_pop_n(rst_n), .init_pop_n(init_n), .pop_req_n(req_n), .data_in(d16),
    .fifo_empty(empty), .pop_wd_n(wd1), .data_out(q1), .part_wd(pw1), .pop_error(pe1));
  asymdata_outbuf #(.in_width(32), .out_width(8), .err_mode(0), .byte_order(0)) u2 (
    .clk_pop(clk), .rst_pop_n(rst_n), .init_pop_n(init_n), .pop_req_n(req_n), .data_in(d32),
    .fifo_empty(empty), .pop_wd_n(wd2), .data_out(q2), .part_wd(pw2), .pop_error(pe2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] exp32 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    #12 rst_n = 1'b1;
    chk("rst_part0", pw0, 0); chk("rst_err0", pe0, 0); chk("rst_wd0", wd0, 1);
    chk("rst_part2", pw2, 0); chk("rst_q0", q0, 8'hA5); chk("rst_q1", q1, 8'h5A);
    chk("rst_q2", q2, 8'h01);
    req_n = 1'b0; #1;
    chk("p0_q0", q0, 8'hA5); chk("p0_wd0", wd0, 1);
    chk("p0_q1", q1, 8'h5A); chk("p0_wd1", wd1, 1);
    tick();
    chk("p1_part0", pw0, 1); chk("p1_q0", q0, 8'h5A); chk("p1_wd0", wd0, 0);
    chk("p1_q1", q1, 8'hA5); chk("p1_wd1", wd1, 0); chk("p1_wd2", wd2, 1);
    tick(); req_n = 1'b1; #1;
    chk("p2_part0", pw0, 0); chk("p2_part1", pw1, 0); chk("p2_part2", pw2, 1);
    chk("p2_q2", q2, 8'h03); chk("idle_wd0", wd0, 1);
    init_n = 1'b0; tick(); init_n = 1'b1; #1;
    chk("init_part2", pw2, 0); chk("init_q2", q2, 8'h01);
    req_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d32 = (i < 4) ? 32'h01020304 : 32'h05060708;
      #1;
      chk($sformatf("w32_q%0d", i), q2, exp32[i]);
      chk($sformatf("w32_wd%0d", i), wd2, (i == 3 || i == 7) ? 1'b0 : 1'b1);
      tick();
    end
    chk("w32_part_end", pw2, 0);
    tick();
    empty = 1'b1; #1;
    chk("uf_wd0", wd0, 1); chk("uf_err_now", pe0, 0);
    tick(); req_n = 1'b1; #1;
    chk("uf_err0", pe0, 1); chk("uf_err1", pe1, 1);
    chk("uf_hold_part0", pw0, 1); chk("uf_hold_q0", q0, 8'h5A);
    tick();
    chk("uf_sticky0", pe0, 1); chk("uf_pulse1", pe1, 0);
    tick();
    chk("uf_sticky0b", pe0, 1);
    init_n = 1'b0; tick(); init_n = 1'b1; empty = 1'b0; #1;
    chk("init_err0", pe0, 0); chk("init_part0", pw0, 0);
    req_n = 1'b0; tick(); req_n = 1'b1; #1;
    chk("mid_part0", pw0, 1);
    rst_n = 1'b0; #1;
    chk("arst_part0", pw0, 0); chk("arst_q0", q0, 8'hA5); chk("arst_part1", pw1, 0);
    tick(); rst_n = 1'b1; req_n = 1'b0; #1;
    chk("post_rst_q0", q0, 8'hA5); chk("post_rst_wd0", wd0, 1);
    tick(); init_n = 1'b0; #1;
    chk("init_pop_wd0", wd0, 0); chk("init_pop_wd1", wd1, 0);
    tick(); init_n = 1'b1; req_n = 1'b1; #1;
    chk("init_pop_part0", pw0, 0); chk("init_pop_err0", pe0, 0); chk("init_pop_q0", q0, 8'hA5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
